// File: rtl/sine_gain_ramp.sv
// sine_gain_ramp: per-channel gain stage with linear click-free gain ramps.
// Samples pass through a five-state pipeline (IDLE, GAIN, MULT, OUT, HOLD).
// Each accepted sample of channel c moves the current gain of c one step
// toward its target. The product is shifted back to sample width and
// saturated.
// Optional build macro SINE_GAIN_RAMP_ROUND_EN: round half up before the
// shift instead of flooring.
module sine_gain_ramp #(
  parameter int NR_CHANNELS = 2,
  parameter int INPUT_WIDTH = 24,
  parameter int GAIN_WIDTH  = 16,
  localparam int CHANNEL_WIDTH = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [GAIN_WIDTH-1:0]     gain_target,
  input  logic [GAIN_WIDTH-1:0]     gain_step,
  input  logic [CHANNEL_WIDTH-1:0]  gain_ch,
  input  logic                      gain_wr,
  output logic [NR_CHANNELS-1:0]    ramp_busy,
  input  logic [INPUT_WIDTH-1:0]    s_d,
  input  logic [CHANNEL_WIDTH-1:0]  s_ch,
  input  logic                      s_dv,
  output logic                      s_dr,
  output logic [INPUT_WIDTH-1:0]    m_d,
  output logic [CHANNEL_WIDTH-1:0]  m_ch,
  output logic                      m_dv,
  input  logic                      m_dr
);

  // Full product width: signed sample times gain zero-extended to signed.
  localparam int PW    = INPUT_WIDTH + GAIN_WIDTH + 1;
  localparam int SHIFT = GAIN_WIDTH - 1;

  localparam logic signed [PW-1:0] MAX_C =
    {{(PW-INPUT_WIDTH+1){1'b0}}, {(INPUT_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_C =
    {{(PW-INPUT_WIDTH+1){1'b1}}, {(INPUT_WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] ROUND_C =
    {{(PW-GAIN_WIDTH+1){1'b0}}, 1'b1, {(GAIN_WIDTH-2){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAIN = 3'd1,
    ST_MULT = 3'd2,
    ST_OUT  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  // True when ch addresses an existing channel.
  function automatic logic ch_ok(input logic [CHANNEL_WIDTH-1:0] ch);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NR_CHANNELS; i++) begin
      if (ch == i[CHANNEL_WIDTH-1:0]) begin
        ok = 1'b1;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // One ramp step toward the target. The one-bit-wider sums cannot overflow,
  // and the result is clamped at the target so it never overshoots.
  function automatic logic [GAIN_WIDTH-1:0] ramp_next(
    input logic [GAIN_WIDTH-1:0] cur,
    input logic [GAIN_WIDTH-1:0] tgt,
    input logic [GAIN_WIDTH-1:0] step
  );
    logic [GAIN_WIDTH:0]   up;
    logic [GAIN_WIDTH:0]   dn;
    logic [GAIN_WIDTH-1:0] r;
    up = {1'b0, cur} + {1'b0, step};
    dn = {1'b0, cur} - {1'b0, step};
    if (step == {GAIN_WIDTH{1'b0}}) begin
      r = tgt;
    end else if (cur < tgt) begin
      r = (up > {1'b0, tgt}) ? tgt : up[GAIN_WIDTH-1:0];
    end else if (cur > tgt) begin
      r = (dn[GAIN_WIDTH] || (dn[GAIN_WIDTH-1:0] < tgt)) ? tgt : dn[GAIN_WIDTH-1:0];
    end else begin
      r = tgt;
    end
    return r;
  endfunction

  state_t                    state_q;
  logic                      s_dr_q;
  logic                      m_dv_q;
  logic [INPUT_WIDTH-1:0]    m_d_q;
  logic [CHANNEL_WIDTH-1:0]  m_ch_q;
  logic [INPUT_WIDTH-1:0]    sample_q;
  logic [CHANNEL_WIDTH-1:0]  ch_q;
  logic                      ch_ok_q;
  logic [GAIN_WIDTH-1:0]     gain_use_q;
  logic signed [PW-1:0]      prod_q;

  logic [GAIN_WIDTH-1:0]     gain_q   [NR_CHANNELS];
  logic [GAIN_WIDTH-1:0]     gain_d   [NR_CHANNELS];
  logic [GAIN_WIDTH-1:0]     target_q [NR_CHANNELS];
  logic [GAIN_WIDTH-1:0]     target_d [NR_CHANNELS];
  logic [GAIN_WIDTH-1:0]     step_q   [NR_CHANNELS];
  logic [GAIN_WIDTH-1:0]     step_d   [NR_CHANNELS];
  logic [NR_CHANNELS-1:0]    busy_q;
  logic [NR_CHANNELS-1:0]    busy_d;

  logic [GAIN_WIDTH-1:0]     next_gain_s;
  logic signed [PW-1:0]      a_ext_s;
  logic signed [PW-1:0]      g_ext_s;
  logic signed [PW-1:0]      prod_s;
  logic signed [PW-1:0]      rnd_s;
  logic signed [PW-1:0]      sh_s;
  logic [INPUT_WIDTH-1:0]    sat_s;

  // Gain for the sample sitting in GAIN, from the channel's ramp state.
  always_comb begin
    next_gain_s = {GAIN_WIDTH{1'b0}};
    if (ch_ok_q) begin
      next_gain_s = ramp_next(gain_q[ch_q], target_q[ch_q], step_q[ch_q]);
    end else begin
      next_gain_s = {GAIN_WIDTH{1'b0}};
    end
  end

  // Next-state of the per-channel gain, target, step and busy registers.
  always_comb begin
    gain_d   = gain_q;
    target_d = target_q;
    step_d   = step_q;
    busy_d   = {NR_CHANNELS{1'b0}};
    if (gain_wr && ch_ok(gain_ch)) begin
      target_d[gain_ch] = gain_target;
      step_d[gain_ch]   = gain_step;
    end else begin
      target_d = target_q;
    end
    if ((state_q == ST_GAIN) && ch_ok_q) begin
      gain_d[ch_q] = next_gain_s;
    end else begin
      gain_d = gain_q;
    end
    for (int c = 0; c < NR_CHANNELS; c++) begin
      busy_d[c] = (gain_d[c] != target_d[c]);
    end
  end

  // Multiply, optional rounding, arithmetic shift and saturation.
  always_comb begin
    a_ext_s = {{(PW-INPUT_WIDTH){sample_q[INPUT_WIDTH-1]}}, sample_q};
    g_ext_s = {{(PW-GAIN_WIDTH){1'b0}}, gain_use_q};
    prod_s  = a_ext_s * g_ext_s;
`ifdef SINE_GAIN_RAMP_ROUND_EN
    rnd_s   = prod_q + ROUND_C;
`else
    rnd_s   = prod_q;
`endif
    sh_s    = rnd_s >>> SHIFT;
    if (!ch_ok_q) begin
      sat_s = {INPUT_WIDTH{1'b0}};
    end else if (sh_s > MAX_C) begin
      sat_s = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
    end else if (sh_s < MIN_C) begin
      sat_s = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
    end else begin
      sat_s = sh_s[INPUT_WIDTH-1:0];
    end
  end

  // Per-channel gain state; reset mutes every channel so startup fades in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NR_CHANNELS; c++) begin
        gain_q[c]   <= {GAIN_WIDTH{1'b0}};
        target_q[c] <= {GAIN_WIDTH{1'b0}};
        step_q[c]   <= {GAIN_WIDTH{1'b0}};
      end
      busy_q <= {NR_CHANNELS{1'b0}};
    end else begin
      gain_q   <= gain_d;
      target_q <= target_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
    end
  end

  // Sample pipeline FSM with registered handshake and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s_dr_q     <= 1'b1;
      m_dv_q     <= 1'b0;
      m_d_q      <= {INPUT_WIDTH{1'b0}};
      m_ch_q     <= {CHANNEL_WIDTH{1'b0}};
      sample_q   <= {INPUT_WIDTH{1'b0}};
      ch_q       <= {CHANNEL_WIDTH{1'b0}};
      ch_ok_q    <= 1'b0;
      gain_use_q <= {GAIN_WIDTH{1'b0}};
      prod_q     <= {PW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_dv) begin
            sample_q <= s_d;
            ch_q     <= s_ch;
            ch_ok_q  <= ch_ok(s_ch);
            s_dr_q   <= 1'b0;
            state_q  <= ST_GAIN;
          end else begin
            s_dr_q   <= 1'b1;
          end
        end
        ST_GAIN: begin
          gain_use_q <= next_gain_s;
          state_q    <= ST_MULT;
        end
        ST_MULT: begin
          prod_q  <= prod_s;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          m_d_q   <= sat_s;
          m_ch_q  <= ch_q;
          m_dv_q  <= 1'b1;
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (m_dr) begin
            m_dv_q  <= 1'b0;
            s_dr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            m_dv_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          s_dr_q  <= 1'b1;
          m_dv_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_dr      = s_dr_q;
  assign m_dv      = m_dv_q;
  assign m_d       = m_d_q;
  assign m_ch      = m_ch_q;
  assign ramp_busy = busy_q;

endmodule

// File: tb/tb_sine_gain_ramp.sv
// Self-checking bench for sine_gain_ramp: directed scenarios plus randomized
// traffic against an arithmetic model of gains, ramps and scaling.
module tb_sine_gain_ramp;

  logic        clk;
  logic        rst_n;
  logic [15:0] gain_target;
  logic [15:0] gain_step;
  logic        gain_ch;
  logic        gain_wr;
  logic [1:0]  ramp_busy;
  logic [23:0] s_d;
  logic        s_ch;
  logic        s_dv;
  logic        s_dr;
  logic [23:0] m_d;
  logic        m_ch;
  logic        m_dv;
  logic        m_dr;

  int checks;
  int errors;

  // Reference state: current gain, target and step per channel.
  int mdl_cur [2];
  int mdl_tgt [2];
  int mdl_stp [2];

  sine_gain_ramp dut (
    .clk(clk), .rst_n(rst_n),
    .gain_target(gain_target), .gain_step(gain_step),
    .gain_ch(gain_ch), .gain_wr(gain_wr), .ramp_busy(ramp_busy),
    .s_d(s_d), .s_ch(s_ch), .s_dv(s_dv), .s_dr(s_dr),
    .m_d(m_d), .m_ch(m_ch), .m_dv(m_dv), .m_dr(m_dr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mdl_cur[c] = 0; mdl_tgt[c] = 0; mdl_stp[c] = 0;
    end
  endtask

  task automatic model_write(input int ch, input int t, input int s);
    mdl_tgt[ch] = t;
    mdl_stp[ch] = s;
  endtask

  // Advance channel gain one step, then scale the sample with it.
  task automatic model_sample(input logic [23:0] d, input int ch, output logic [23:0] exp);
    int c, t, s;
    longint p, q;
    c = mdl_cur[ch]; t = mdl_tgt[ch]; s = mdl_stp[ch];
    if (s == 0)      c = t;
    else if (c < t)  c = (c + s > t) ? t : c + s;
    else if (c > t)  c = (c - s < t) ? t : c - s;
    mdl_cur[ch] = c;
    p = longint'($signed(d)) * longint'(c);
`ifdef SINE_GAIN_RAMP_ROUND_EN
    p = p + 64'sd16384;
`endif
    q = p >>> 15;
    if (q > 64'sd8388607) q = 64'sd8388607;
    if (q < -64'sd8388608) q = -64'sd8388608;
    exp = q[23:0];
  endtask

  function automatic logic [1:0] model_busy();
    logic [1:0] b;
    for (int c = 0; c < 2; c++) b[c] = (mdl_cur[c] != mdl_tgt[c]);
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_gain(input logic ch, input logic [15:0] t, input logic [15:0] s);
    @(negedge clk);
    gain_ch = ch; gain_target = t; gain_step = s; gain_wr = 1'b1;
    @(posedge clk); #1;
    gain_wr = 1'b0;
    model_write(int'(ch), int'(t), int'(s));
  endtask

  // Push one sample (optionally with a same-edge gain write for its channel),
  // return the output seen and the accept-to-valid latency in edges (-1 if none).
  task automatic run_sample(input logic [23:0] d, input logic ch, input logic wr,
                            input logic [15:0] wt, input logic [15:0] ws,
                            output logic [23:0] od, output logic och, output int lat);
    int n;
    lat = -1; od = 24'h0; och = 1'b0; n = 0;
    @(negedge clk);
    while (!s_dr && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (s_dr) begin
      s_d = d; s_ch = ch; s_dv = 1'b1;
      if (wr) begin
        gain_ch = ch; gain_target = wt; gain_step = ws; gain_wr = 1'b1;
      end
      @(posedge clk); #1;
      s_dv = 1'b0; gain_wr = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (m_dv) begin
          lat = k;
          break;
        end
      end
      od = m_d; och = m_ch;
      if (m_dr && lat > 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] od, exp;
    logic och;
    int lat;
    do_reset();
    checks++;
    if (s_dr !== 1'b1 || m_dv !== 1'b0 || m_d !== 24'h0 || m_ch !== 1'b0 || ramp_busy !== 2'b00) begin
      $display("FAIL reset_state: s_dr=%b m_dv=%b m_d=%h m_ch=%b busy=%b, want 1 0 000000 0 00",
               s_dr, m_dv, m_d, m_ch, ramp_busy);
      errors++;
    end
    run_sample(24'h400000, 1'b0, 1'b0, 16'h0, 16'h0, od, och, lat);
    model_sample(24'h400000, 0, exp);
    checks++;
    if (od !== 24'h000000 || od !== exp || och !== 1'b0) begin
      $display("FAIL muted_after_reset: m_d=%h m_ch=%b, want 000000 0", od, och);
      errors++;
    end
    checks++;
    if (lat !== 3) begin
      $display("FAIL latency: got %0d edges, want 3", lat);
      errors++;
    end
  endtask

  task automatic test_unity_jump();
    logic [23:0] od, exp;
    logic och;
    int lat;
    write_gain(1'b0, 16'd32768, 16'd0);
    checks++;
    if (ramp_busy !== 2'b01) begin
      $display("FAIL busy_after_write: got %b want 01", ramp_busy);
      errors++;
    end
    run_sample(24'h400000, 1'b0, 1'b0, 16'h0, 16'h0, od, och, lat);
    model_sample(24'h400000, 0, exp);
    checks++;
    if (od !== 24'h400000 || od !== exp) begin
      $display("FAIL unity_jump: m_d=%h want 400000", od);
      errors++;
    end
    checks++;
    if (ramp_busy[0] !== 1'b0) begin
      $display("FAIL busy_after_jump: got %b want 0", ramp_busy[0]);
      errors++;
    end
  endtask

  task automatic test_ramp();
    logic [23:0] od, exp, d0;
    logic och;
    int lat;
    logic [23:0] want [4];
    want[0] = 24'h040000; want[1] = 24'h080000; want[2] = 24'h0C0000; want[3] = 24'h100000;
    write_gain(1'b1, 16'd32768, 16'd8192);
    for (int i = 0; i < 4; i++) begin
      run_sample(24'h100000, 1'b1, 1'b0, 16'h0, 16'h0, od, och, lat);
      model_sample(24'h100000, 1, exp);
      checks++;
      if (od !== want[i] || od !== exp || och !== 1'b1) begin
        $display("FAIL ramp_step%0d: m_d=%h m_ch=%b, want %h 1", i, od, och, want[i]);
        errors++;
      end
      checks++;
      if (ramp_busy[1] !== (i < 3)) begin
        $display("FAIL ramp_busy_step%0d: got %b want %b", i, ramp_busy[1], (i < 3));
        errors++;
      end
      d0 = 24'($urandom);
      run_sample(d0, 1'b0, 1'b0, 16'h0, 16'h0, od, och, lat);
      model_sample(d0, 0, exp);
      checks++;
      if (od !== d0 || od !== exp || och !== 1'b0) begin
        $display("FAIL ch0_interleave%0d: m_d=%h m_ch=%b, want %h 0", i, od, och, d0);
        errors++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [23:0] od, exp;
    logic och;
    int lat;
    write_gain(1'b0, 16'd65535, 16'd0);
    run_sample(24'h7FFFFF, 1'b0, 1'b0, 16'h0, 16'h0, od, och, lat);
    model_sample(24'h7FFFFF, 0, exp);
    checks++;
    if (od !== 24'h7FFFFF || od !== exp) begin
      $display("FAIL sat_pos: m_d=%h want 7fffff", od);
      errors++;
    end
    run_sample(24'h800000, 1'b0, 1'b0, 16'h0, 16'h0, od, och, lat);
    model_sample(24'h800000, 0, exp);
    checks++;
    if (od !== 24'h800000 || od !== exp) begin
      $display("FAIL sat_neg: m_d=%h want 800000", od);
      errors++;
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] od, exp;
    logic och;
    int lat, bad;
    write_gain(1'b1, 16'd32768, 16'd0);
    m_dr = 1'b0;
    run_sample(24'h123456, 1'b1, 1'b0, 16'h0, 16'h0, od, och, lat);
    model_sample(24'h123456, 1, exp);
    checks++;
    if (lat !== 3 || od !== exp || och !== 1'b1) begin
      $display("FAIL bp_output: lat=%0d m_d=%h m_ch=%b, want 3 %h 1", lat, od, och, exp);
      errors++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_dv !== 1'b1 || m_d !== exp || m_ch !== 1'b1 || s_dr !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL bp_hold: %0d cycles unstable, want 0 (m_dv=%b m_d=%h s_dr=%b)", bad, m_dv, m_d, s_dr);
      errors++;
    end
    m_dr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_dv !== 1'b0 || s_dr !== 1'b1) begin
      $display("FAIL bp_release: m_dv=%b s_dr=%b, want 0 1", m_dv, s_dr);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] od, exp;
    logic och;
    int lat, bad;
    write_gain(1'b0, 16'd32768, 16'd0);
    @(negedge clk);
    s_d = 24'h200000; s_ch = 1'b0; s_dv = 1'b1;
    @(posedge clk); #1;
    s_dv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (m_dv !== 1'b0 || s_dr !== 1'b1 || ramp_busy !== 2'b00 || m_d !== 24'h0) begin
      $display("FAIL reset_mid: m_dv=%b s_dr=%b busy=%b m_d=%h, want 0 1 00 000000",
               m_dv, s_dr, ramp_busy, m_d);
      errors++;
    end
    rst_n = 1'b1;
    model_reset();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_dv !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL reset_discard: m_dv high %0d cycles, want 0", bad);
      errors++;
    end
    run_sample(24'h400000, 1'b0, 1'b0, 16'h0, 16'h0, od, och, lat);
    model_sample(24'h400000, 0, exp);
    checks++;
    if (od !== 24'h0 || od !== exp) begin
      $display("FAIL reset_gain_zero: m_d=%h want 000000", od);
      errors++;
    end
  endtask

  task automatic test_rounding();
    logic [23:0] od, exp, w_pos, w_neg;
    logic och;
    int lat;
`ifdef SINE_GAIN_RAMP_ROUND_EN
    w_pos = 24'd2; w_neg = 24'hFFFFFF;
`else
    w_pos = 24'd1; w_neg = 24'hFFFFFE;
`endif
    write_gain(1'b0, 16'd16384, 16'd0);
    run_sample(24'd3, 1'b0, 1'b0, 16'h0, 16'h0, od, och, lat);
    model_sample(24'd3, 0, exp);
    checks++;
    if (od !== w_pos || od !== exp) begin
      $display("FAIL round_pos: m_d=%h want %h", od, w_pos);
      errors++;
    end
    run_sample(24'hFFFFFD, 1'b0, 1'b0, 16'h0, 16'h0, od, och, lat);
    model_sample(24'hFFFFFD, 0, exp);
    checks++;
    if (od !== w_neg || od !== exp) begin
      $display("FAIL round_neg: m_d=%h want %h", od, w_neg);
      errors++;
    end
  endtask

  function automatic logic [15:0] rand_step();
    case ($urandom_range(0, 3))
      0: return 16'd0;
      1: return 16'($urandom_range(1, 255));
      2: return 16'($urandom_range(256, 20000));
      default: return 16'd65535;
    endcase
  endfunction

  task automatic test_random();
    logic [23:0] od, exp, d;
    logic och, ch, wr;
    logic [15:0] wt, ws;
    int lat;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0)
        write_gain(1'($urandom), 16'($urandom), rand_step());
      d  = 24'($urandom);
      ch = 1'($urandom);
      wr = ($urandom_range(0, 3) == 0);
      wt = 16'($urandom);
      ws = rand_step();
      run_sample(d, ch, wr, wt, ws, od, och, lat);
      if (wr) model_write(int'(ch), int'(wt), int'(ws));
      model_sample(d, int'(ch), exp);
      checks++;
      if (od !== exp || och !== ch || lat !== 3) begin
        $display("FAIL random%0d: m_d=%h m_ch=%b lat=%0d, want %h %b 3", i, od, och, lat, exp, ch);
        errors++;
      end
      checks++;
      if (ramp_busy !== model_busy()) begin
        $display("FAIL random_busy%0d: got %b want %b", i, ramp_busy, model_busy());
        errors++;
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; gain_target = 16'h0; gain_step = 16'h0; gain_ch = 1'b0; gain_wr = 1'b0;
    s_d = 24'h0; s_ch = 1'b0; s_dv = 1'b0; m_dr = 1'b1;
    model_reset();
    test_reset();
    test_unity_jump();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_rounding();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
